// File: rtl/inst_mem_fetch.sv
// ---------------------------------------------------------------------------
// inst_mem_fetch
// Synchronous instruction memory for the CPU fetch stage. A fetch request is
// accepted with a valid/ready handshake and answered one cycle later from a
// single response holding register, which also absorbs fetch stalls. A
// program-load write port fills the array at run time. Locations that were
// never written since reset, or that lie beyond DEPTH, read as 0 (NOP).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  fetch request valid
//   req_ready  request accepted when req_valid && req_ready
//   req_addr   fetch word address
//   rsp_valid  response valid
//   rsp_ready  consumer accepts response
//   rsp_inst   fetched instruction
//   rsp_addr   address the response belongs to
//   rsp_err    requested address was >= DEPTH
//   prog_we    program-load write strobe
//   prog_addr  program-load word address
//   prog_data  program-load data
//   prog_cnt   number of distinct words written since reset
// ---------------------------------------------------------------------------
module inst_mem_fetch #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W:0]   prog_cnt
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_wr_vld;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_inst;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic              r_rsp_err;
  logic [ADDR_W:0]   r_prog_cnt;

  logic              w_req_in_range;
  logic              w_prog_hit;
  logic              w_req_fire;
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_data;

  assign w_req_in_range = {1'b0, req_addr} < DEPTH_C;
  assign w_prog_hit     = prog_we && ({1'b0, prog_addr} < DEPTH_C);

  // The holding register can take a new response when it is empty or is
  // being emptied this very cycle, giving one fetch per cycle.
  assign req_ready  = !r_rsp_valid || rsp_ready;
  assign w_req_fire = req_valid && req_ready;

  // A load to the address being fetched in the same cycle wins (write-first).
  assign w_bypass = w_prog_hit && (prog_addr == req_addr);

  // Read data for the response register: bypass, stored word, or NOP for
  // never-written and out-of-range locations.
  always_comb begin
    w_rd_data = '0;
    if (w_req_in_range) begin
      if (w_bypass) begin
        w_rd_data = prog_data;
      end else if (r_wr_vld[req_addr]) begin
        w_rd_data = r_mem[req_addr];
      end
    end
  end

  // Array contents are deliberately not reset; the written flags decide
  // whether a word is visible, so clearing the flags is enough.
  always_ff @(posedge clk) begin
    if (w_prog_hit) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Written flags and distinct-word counter. Rewrites of an already flagged
  // word do not count, so the counter can never pass DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vld   <= '0;
      r_prog_cnt <= '0;
    end else if (w_prog_hit) begin
      r_wr_vld[prog_addr] <= 1'b1;
      if (!r_wr_vld[prog_addr]) begin
        r_prog_cnt <= r_prog_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Response holding register. Loading only on an accepted request keeps the
  // payload frozen during a stall, even if the held address is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_inst  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_inst  <= w_rd_data;
      r_rsp_addr  <= req_addr;
      r_rsp_err   <= !w_req_in_range;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_inst  = r_rsp_inst;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;
  assign prog_cnt  = r_prog_cnt;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_fetch
// Scoreboard bench for inst_mem_fetch, built with DEPTH=48 so out-of-range
// addresses exist. The driver predicts responses from a word-level model of
// the memory and queues them; a separate monitor compares each cycle.
// ---------------------------------------------------------------------------
module tb_inst_mem_fetch;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 48;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] inst;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, prog_we;
  logic [AW-1:0] req_addr, rsp_addr, prog_addr;
  logic [DW-1:0] rsp_inst, prog_data;
  logic [AW:0]   prog_cnt;

  // Reference model state
  logic [DW-1:0] mMem [64];
  bit            mWr [64];
  int            mCnt;
  bit            mValid;
  bit            expReqReady;
  rsp_t          q[$];
  rsp_t          staged;
  bit            stagedValid;
  bit            sWe;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sData;

  int nChecks = 0;
  int nPass   = 0;

  inst_mem_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_cnt(prog_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of inputs just after a rising edge, first committing the
  // prediction made for the edge that just happened.
  task automatic applyStimulus(input bit rv, input logic [AW-1:0] ra, input bit rr,
                               input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
    bit   accept;
    rsp_t e;
    @(posedge clk);
    #1;
    if (stagedValid) q.push_back(staged);
    stagedValid = 0;
    if (sWe && sAddr < DEPTH) begin
      if (!mWr[sAddr]) mCnt++;
      mWr[sAddr]  = 1;
      mMem[sAddr] = sData;
    end
    sWe = pw; sAddr = pa; sData = pd;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    prog_we = pw; prog_addr = pa; prog_data = pd;
    expReqReady = !mValid || rr;
    accept = rv && expReqReady;
    if (accept) begin
      e.addr = ra;
      e.err  = (ra >= DEPTH);
      if (e.err)                e.inst = '0;
      else if (pw && pa == ra)  e.inst = pd;
      else if (mWr[ra])         e.inst = mMem[ra];
      else                      e.inst = '0;
      staged = e;
      stagedValid = 1;
      mValid = 1;
    end else if (rr) begin
      mValid = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 1, 0, '0, '0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 0; rsp_ready = 1; prog_we = 0;
    q.delete();
    stagedValid = 0; sWe = 0; mValid = 0; mCnt = 0; expReqReady = 1;
    for (int i = 0; i < 64; i++) mWr[i] = 0;
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_inst", rsp_inst, 32'd0);
    checkOutput("reset_rsp_addr", 32'(rsp_addr), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_prog_cnt", 32'(prog_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: mid-cycle, compares handshake, counter and the held response
  // against the front of the scoreboard; pops when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("req_ready", 32'(req_ready), 32'(expReqReady));
      checkOutput("prog_cnt", 32'(prog_cnt), 32'(mCnt));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0));
      if (rsp_valid === 1'b1 && q.size() > 0) begin
        checkOutput("rsp_inst", rsp_inst, q[0].inst);
        checkOutput("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
        checkOutput("rsp_err", 32'(rsp_err), 32'(q[0].err));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_addr = '0; rsp_ready = 1;
    prog_we = 0; prog_addr = '0; prog_data = '0;
    mCnt = 0; mValid = 0; expReqReady = 1; stagedValid = 0; sWe = 0;
    for (int i = 0; i < 64; i++) begin mWr[i] = 0; mMem[i] = '0; end
    doReset();

    // Fetch from an unwritten location returns NOP
    applyStimulus(1, 6'h01, 1, 0, '0, '0);
    idle(2);

    // Load a short program, then stream fetches back to back
    applyStimulus(0, '0, 1, 1, 6'd1, 32'h3c000862);
    applyStimulus(0, '0, 1, 1, 6'd2, 32'h00100841);
    applyStimulus(0, '0, 1, 1, 6'd3, 32'h48000001);
    applyStimulus(1, 6'd1, 1, 0, '0, '0);
    applyStimulus(1, 6'd2, 1, 0, '0, '0);
    applyStimulus(1, 6'd3, 1, 0, '0, '0);
    idle(2);

    // Stall with addr 2 pending for three cycles, rewriting it meanwhile
    applyStimulus(1, 6'd2, 1, 0, '0, '0);
    applyStimulus(1, 6'd3, 0, 1, 6'd2, 32'hdeadbeef);
    applyStimulus(1, 6'd3, 0, 0, '0, '0);
    applyStimulus(1, 6'd3, 0, 0, '0, '0);
    applyStimulus(1, 6'd3, 1, 0, '0, '0);
    idle(2);

    // Same-cycle write/read collision, then a rewrite that must not count
    applyStimulus(1, 6'd4, 1, 1, 6'd4, 32'h00100443);
    applyStimulus(0, '0, 1, 1, 6'd4, 32'h04101025);
    applyStimulus(1, 6'd4, 1, 0, '0, '0);
    idle(2);

    // Out of range: error flag, NOP data, load ignored
    applyStimulus(1, 6'h30, 1, 1, 6'h30, 32'h12345678);
    applyStimulus(1, 6'h3f, 1, 0, '0, '0);
    idle(2);

    // Reset while a response is held
    applyStimulus(1, 6'd1, 0, 0, '0, '0);
    applyStimulus(0, '0, 0, 0, '0, '0);
    doReset();
    applyStimulus(1, 6'd1, 1, 0, '0, '0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, 63)), $urandom);
    end
    idle(4);
    checkOutput("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/inst_mem_fetch.md
Name: inst_mem_fetch

Overview:
Parametrised, synchronous instruction memory for the CPU fetch stage, successor to the fixed 64x32 combinational instruction ROM.
- Adds a registered read with a valid/ready request/response handshake and a one-entry response holding register for fetch stalls.
- Adds a program-load write port, so test programs are loaded at run time instead of hard-coded.
- Unwritten and out-of-range locations read as 32'h00000000, the NOP encoding.

Parameters:
ADDR_W, 6, word-address width
DATA_W, 32, instruction width
DEPTH, 64, number of implemented words (1..2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  ADDR_W  fetch word address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_inst  out  DATA_W  fetched instruction
rsp_addr  out  ADDR_W  address the response belongs to
rsp_err  out  1  address was >= DEPTH
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_W  program-load address
prog_data  in  DATA_W  program-load data
prog_cnt  out  ADDR_W+1  number of distinct words written since reset

Behaviour:
Storage and reset
- Array: DEPTH x DATA_W; contents are not reset.
- Per-word written flag wr_vld[DEPTH]; reset clears all flags to 0.

Reset values (asynchronous, on rst_n=0):
- rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_err=0, prog_cnt=0, all wr_vld=0.
- Reset mid-transaction drops any in-flight response; no response appears after reset release unless a new request is made.

Program-load writes
- On a posedge with prog_we=1 and prog_addr<DEPTH: mem[prog_addr]<=prog_data and wr_vld[prog_addr]<=1.
- prog_cnt increments only if wr_vld[prog_addr] was 0 before the write. Rewrites do not count.
- prog_we with prog_addr>=DEPTH is ignored: no write, no count.

Handshake (single output stage)
- req_ready = !rsp_valid || rsp_ready, purely combinational.
- Accept: req_valid && req_ready at a posedge. Next cycle rsp_valid=1, with:
  - rsp_addr = req_addr.
  - rsp_err = (req_addr>=DEPTH).
  - rsp_inst = mem[req_addr] if wr_vld[req_addr]=1 and the address is in range; otherwise 0.
- Latency is exactly 1 cycle from acceptance to rsp_valid.
- Stall: while rsp_valid && !rsp_ready, rsp_inst, rsp_addr and rsp_err hold stable, and req_ready=0.
- Drain: rsp_valid && rsp_ready with no accepted request clears rsp_valid to 0 on the next edge.
- Back-to-back: rsp_valid && rsp_ready with an accepted request loads the new response in the same edge. This gives a throughput of 1 fetch per cycle.

Write/read collision
- prog_we to an address in the same cycle a request to that address is accepted: the response returns prog_data (write-first bypass).
- A prog write to the address of a response already held during a stall does NOT change the held rsp_inst.

Widths
- prog_cnt saturates at DEPTH (it cannot exceed it by construction).
- req_addr compared against DEPTH unsigned. When DEPTH==2**ADDR_W, rsp_err is always 0.

Test Plan:
- Reset, no writes; request addr 0x01 -> next cycle rsp_valid=1, rsp_inst=0x00000000, rsp_addr=0x01, rsp_err=0.
- Load 0x3c000862@1, 0x00100841@2, 0x48000001@3; req_valid held high with addrs 1,2,3 and rsp_ready=1 -> responses 0x3c000862, 0x00100841, 0x48000001 on consecutive cycles; prog_cnt=3.
- Stall: rsp_ready=0 for 3 cycles with response 0x00100841 pending and req_valid=1 -> req_ready=0 and the output stays constant for those 3 cycles. Raise rsp_ready -> the next request is accepted and completes with no lost or duplicated response.
- Collision: prog_we to addr 4 with data 0x00100443 in the same cycle as an accepted request to addr 4 -> rsp_inst=0x00100443. Rewrite addr 4 with 0x04101025 -> prog_cnt unchanged.
- DEPTH=48: request addr 0x30 -> rsp_err=1, rsp_inst=0. prog_we to 0x30 -> no count change.
- Assert rst_n=0 while a response is held -> rsp_valid=0 immediately. After release, a request to addr 1 -> rsp_inst=0 (wr_vld cleared) and prog_cnt=0.
